// File: rtl/shuffle_perm_gen.sv
// shuffle_perm_gen: sequential generator of 8-lane shuffle destination vectors per stage
module shuffle_perm_gen #(
  parameter int ROUNDS    = 4,
  parameter int BITREV_EN = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       mode,
  input  logic       abort,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [2:0] a0,
  output logic [2:0] a1,
  output logic [2:0] a2,
  output logic [2:0] a3,
  output logic [2:0] a4,
  output logic [2:0] a5,
  output logic [2:0] a6,
  output logic [2:0] a7,
  output logic [1:0] stage_id,
  output logic       busy,
  output logic       done
);
  localparam int P = 3 + BITREV_EN;
  localparam int RW = $clog2(ROUNDS + 1);
  localparam logic [1:0] BLAST = 2'(P - 1);
  localparam logic [RW-1:0] RLAST = RW'(ROUNDS - 1);

  if (ROUNDS < 1) begin : g_bad_rounds
    $error("shuffle_perm_gen: ROUNDS must be >= 1");
  end

  typedef enum logic [1:0] {IDLE, EMIT, DONE} state_t;

  state_t state_q, state_d;
  logic mode_q, mode_d, valid_q, valid_d, busy_q, busy_d, done_q, done_d;
  logic [1:0] beat_q, beat_d, stage_q, stage_d;
  logic [RW-1:0] rnd_q, rnd_d;
  logic [2:0] a_q [8];
  logic [2:0] a_d [8];

  // S0 and BR share the same bit-reversal map; S2 is identity
  function automatic logic [2:0] lane_map(input logic [1:0] s, input logic [2:0] i);
    return (s == 2'd0 || s == 2'd3) ? {i[0], i[1], i[2]} :
           (s == 2'd1) ? {i[2], i[0], i[1]} : i;
  endfunction

  // inverse order walks the pass backwards, so BR (when present) comes first
  function automatic logic [1:0] stage_of(input logic m, input logic [1:0] b);
    return m ? BLAST - b : b;
  endfunction

  // next-state: abort beats everything, then IDLE -> EMIT -> DONE -> IDLE
  always_comb begin
    state_d = state_q;
    mode_d = mode_q;
    beat_d = beat_q;
    rnd_d = rnd_q;
    stage_d = stage_q;
    valid_d = valid_q;
    busy_d = busy_q;
    done_d = 1'b0;
    if (abort) begin
      state_d = IDLE;
      beat_d = '0;
      rnd_d = '0;
      stage_d = '0;
      valid_d = 1'b0;
      busy_d = 1'b0;
    end else if (state_q == IDLE) begin
      if (start) begin
        state_d = EMIT;
        mode_d = mode;
        beat_d = '0;
        rnd_d = '0;
        stage_d = stage_of(mode, 2'd0);
        valid_d = 1'b1;
        busy_d = 1'b1;
      end
    end else if (state_q == EMIT) begin
      if (out_ready) begin
        if (beat_q == BLAST && rnd_q == RLAST) begin
          state_d = DONE;
          beat_d = '0;
          rnd_d = '0;
          stage_d = '0;
          valid_d = 1'b0;
          busy_d = 1'b0;
          done_d = 1'b1;
        end else begin
          beat_d = (beat_q == BLAST) ? 2'd0 : beat_q + 2'd1;
          rnd_d = (beat_q == BLAST) ? rnd_q + RW'(1) : rnd_q;
          stage_d = stage_of(mode_q, beat_d);
        end
      end
    end else begin
      state_d = IDLE;
    end
    for (int i = 0; i < 8; i++) a_d[i] = valid_d ? lane_map(stage_d, 3'(i)) : 3'(i);
  end

  // state and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mode_q <= 1'b0;
      beat_q <= '0;
      rnd_q <= '0;
      stage_q <= '0;
      valid_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      for (int i = 0; i < 8; i++) a_q[i] <= 3'(i);
    end else begin
      state_q <= state_d;
      mode_q <= mode_d;
      beat_q <= beat_d;
      rnd_q <= rnd_d;
      stage_q <= stage_d;
      valid_q <= valid_d;
      busy_q <= busy_d;
      done_q <= done_d;
      a_q <= a_d;
    end
  end

  assign out_valid = valid_q;
  assign busy = busy_q;
  assign done = done_q;
  assign stage_id = stage_q;
  assign {a0, a1, a2, a3, a4, a5, a6, a7} = {a_q[0], a_q[1], a_q[2], a_q[3], a_q[4], a_q[5], a_q[6], a_q[7]};
endmodule
